// File: rtl/strided_addr_generator.sv
// Strided word-address generator with valid/ready output, beat count and optional multi-pass replay.
// Define STRIDED_ADDR_REPEAT_EN to enable repeat_cnt passes; otherwise each run is a single pass.
module strided_addr_generator #(
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 12,
   parameter int BYTE_SHIFT = 2,
   parameter int REP_WIDTH  = 4
) (
   input  logic                  core_clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_address,
   input  logic [ADDR_WIDTH-1:0] stride,
   input  logic [LEN_WIDTH-1:0]  length,
   input  logic [REP_WIDTH-1:0]  repeat_cnt,
   input  logic                  abort,
   input  logic                  addr_ready,
   output logic                  addr_valid,
   output logic [ADDR_WIDTH-1:0] address,
   output logic                  last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] stride_q;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [LEN_WIDTH-1:0]  beat_cnt;

   logic start_ok;
   logic handshake;
   logic beat_last;
   logic pass_last;

   function automatic logic [ADDR_WIDTH-1:0] to_byte_addr(input logic [ADDR_WIDTH-1:0] w);
      return w << BYTE_SHIFT;
   endfunction

   assign start_ok  = (state == ST_IDLE) && start;
   assign handshake = (state == ST_RUN) && addr_ready;
   assign beat_last = (beat_cnt == len_q - 1'b1);

`ifdef STRIDED_ADDR_REPEAT_EN
   logic [REP_WIDTH-1:0] rep_q;
   logic [REP_WIDTH-1:0] pass_cnt;

   assign pass_last = (pass_cnt == rep_q);

   always_ff @(posedge core_clk) begin
      if (reset) begin
         rep_q    <= '0;
         pass_cnt <= '0;
      end else if (start_ok) begin
         rep_q    <= repeat_cnt;
         pass_cnt <= '0;
      end else if (handshake && beat_last && !pass_last) begin
         pass_cnt <= pass_cnt + 1'b1;
      end
   end
`else
   logic unused_repeat;

   assign unused_repeat = ^repeat_cnt;
   assign pass_last     = 1'b1;
`endif

   // State register
   always_ff @(posedge core_clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode; abort outranks the final handshake
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = (length != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (handshake && beat_last && pass_last) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Address/beat datapath; the final handshake leaves the registers holding
   always_ff @(posedge core_clk) begin
      if (reset) begin
         base_q    <= '0;
         stride_q  <= '0;
         len_q     <= '0;
         word_addr <= '0;
         beat_cnt  <= '0;
      end else if (start_ok) begin
         base_q    <= base_address;
         stride_q  <= stride;
         len_q     <= length;
         word_addr <= base_address;
         beat_cnt  <= '0;
      end else if (handshake) begin
         if (!beat_last) begin
            word_addr <= word_addr + stride_q;
            beat_cnt  <= beat_cnt + 1'b1;
         end else if (!pass_last) begin
            word_addr <= base_q;
            beat_cnt  <= '0;
         end
      end
   end

   // Outputs depend on registered state only
   always_comb begin
      addr_valid = (state == ST_RUN);
      busy       = (state != ST_IDLE);
      done       = (state == ST_DONE);
      last       = (state == ST_RUN) && beat_last && pass_last;
      address    = to_byte_addr(word_addr);
   end

endmodule

// File: tb/tb_strided_addr_generator.sv
// Self-checking bench for strided_addr_generator: vector table, corner sequences and
// randomized runs compared against an arithmetic address-list model.
module tb_strided_addr_generator;

   localparam int SHIFT = 2;
`ifdef STRIDED_ADDR_REPEAT_EN
   localparam int REP_ON = 1;
`else
   localparam int REP_ON = 0;
`endif

   logic        core_clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] base_address;
   logic [15:0] stride;
   logic [11:0] length;
   logic [3:0]  repeat_cnt;
   logic        abort;
   logic        addr_ready;
   logic        addr_valid;
   logic [15:0] address;
   logic        last;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   strided_addr_generator #(
      .ADDR_WIDTH(16),
      .LEN_WIDTH (12),
      .BYTE_SHIFT(SHIFT),
      .REP_WIDTH (4)
   ) dut (
      .core_clk    (core_clk),
      .reset       (reset),
      .start       (start),
      .base_address(base_address),
      .stride      (stride),
      .length      (length),
      .repeat_cnt  (repeat_cnt),
      .abort       (abort),
      .addr_ready  (addr_ready),
      .addr_valid  (addr_valid),
      .address     (address),
      .last        (last),
      .busy        (busy),
      .done        (done)
   );

   always #5 core_clk = ~core_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] b;
      logic [15:0] s;
      logic [11:0] l;
      logic [3:0]  r;
      int          rmode;
      logic [15:0] exp_first;
      logic [15:0] exp_last;
      int          exp_beats;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string nm);
      chk({nm, "_valid"}, 32'(addr_valid), 32'd0);
      chk({nm, "_busy"},  32'(busy),       32'd0);
      chk({nm, "_done"},  32'(done),       32'd0);
      chk({nm, "_last"},  32'(last),       32'd0);
   endtask

   // Launches a run at a negedge and follows it to done, checking every beat against the model.
   task automatic do_run(input logic [15:0] b, input logic [15:0] s, input logic [11:0] l,
                         input logic [3:0] r, input int rmode,
                         output logic [15:0] first_a, output logic [15:0] last_a, output int beats);
      logic [15:0] expq[$];
      int passes;
      int total;
      int idx;
      int budget;
      bit hs_prev;
      bit fin;
      bit pat[4];
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      passes = REP_ON ? int'(r) + 1 : 1;
      expq.delete();
      for (int p = 0; p < passes; p++)
         for (int k = 0; k < int'(l); k++)
            expq.push_back(16'((32'(b) + 32'(k) * 32'(s)) << SHIFT));
      total   = expq.size();
      budget  = 8 * total + 20;
      first_a = '0;
      last_a  = '0;
      idx     = 0;
      hs_prev = 1'b0;
      fin     = 1'b0;

      start = 1'b1; base_address = b; stride = s; length = l; repeat_cnt = r;
      abort = 1'b0; addr_ready = 1'b0;
      @(negedge core_clk);
      for (int cyc = 0; cyc < budget && !fin; cyc++) begin
         // Inputs wander after the latch, and start is pulsed while busy.
         start        = 1'($urandom_range(0, 1));
         base_address = 16'($urandom);
         stride       = 16'($urandom);
         length       = 12'($urandom);
         repeat_cnt   = 4'($urandom);
         if (done) begin
            chk("done_timing", 32'((total == 0) ? (cyc == 0) : (hs_prev && idx == total)), 32'd1);
            chk("beats_at_done", 32'(idx), 32'(total));
            chk("valid_in_done", 32'(addr_valid), 32'd0);
            start       = 1'b0;
            addr_ready  = 1'b0;
            fin         = 1'b1;
         end else begin
            chk("busy_in_run", 32'(busy), 32'd1);
            chk("valid_in_run", 32'(addr_valid), 32'(idx < total));
            if (addr_valid && idx < total) begin
               chk("address", 32'(address), 32'(expq[idx]));
               chk("last", 32'(last), 32'(idx == total - 1));
               if (idx == 0) first_a = address;
               last_a = address;
               case (rmode)
                  0:       addr_ready = 1'b1;
                  1:       addr_ready = 1'($urandom_range(0, 1));
                  default: addr_ready = pat[cyc % 4];
               endcase
               hs_prev = addr_ready;
               if (addr_ready) idx++;
            end else begin
               addr_ready = 1'b0;
               hs_prev    = 1'b0;
            end
            @(negedge core_clk);
         end
      end
      if (!fin) begin
         chk("run_timeout", 32'd0, 32'd1);
         reset = 1'b1;
         @(negedge core_clk);
         reset = 1'b0;
      end else begin
         @(negedge core_clk);
         chk_idle_outputs("after_done");
      end
      beats = idx;
   endtask

   logic [15:0] fa, la;
   int          nb;

   initial begin
      vt[0] = '{16'h0010, 16'h0001, 12'd4, 4'd0, 0, 16'h0040, 16'h004C, 4};
      vt[1] = '{16'h0100, 16'h0003, 12'd3, 4'd2, 0, 16'h0400, 16'h0418, REP_ON ? 9 : 3};
      vt[2] = '{16'hFFFE, 16'h0001, 12'd3, 4'd0, 0, 16'hFFF8, 16'h0000, 3};
      vt[3] = '{16'h0010, 16'h0001, 12'd4, 4'd0, 2, 16'h0040, 16'h004C, 4};
      vt[4] = '{16'h0055, 16'h0007, 12'd0, 4'd3, 0, 16'h0000, 16'h0000, 0};
      vt[5] = '{16'h1234, 16'hFFFF, 12'd5, 4'd1, 2, 16'h48D0, 16'h48C0, REP_ON ? 10 : 5};

      reset = 1'b1; start = 1'b0; base_address = '0; stride = '0; length = '0;
      repeat_cnt = '0; abort = 1'b0; addr_ready = 1'b0;
      repeat (3) @(negedge core_clk);
      chk_idle_outputs("reset");
      chk("reset_address", 32'(address), 32'd0);
      reset = 1'b0;
      @(negedge core_clk);

      for (int i = 0; i < 6; i++) begin
         do_run(vt[i].b, vt[i].s, vt[i].l, vt[i].r, vt[i].rmode, fa, la, nb);
         chk("tbl_first", 32'(fa), 32'(vt[i].exp_first));
         chk("tbl_last",  32'(la), 32'(vt[i].exp_last));
         chk("tbl_beats", 32'(nb), 32'(vt[i].exp_beats));
      end

      // Abort on the second beat of an 8-beat run
      start = 1'b1; base_address = 16'h0200; stride = 16'h0002; length = 12'd8;
      repeat_cnt = 4'd0; addr_ready = 1'b1;
      @(negedge core_clk);
      start = 1'b0;
      chk("abort_beat0", 32'(address), 32'h0800);
      @(negedge core_clk);
      chk("abort_beat1", 32'(address), 32'h0808);
      abort = 1'b1;
      @(negedge core_clk);
      abort = 1'b0;
      chk_idle_outputs("abort");
      @(negedge core_clk);
      chk("abort_no_done", 32'(done), 32'd0);

      // Abort together with the final handshake: no done
      start = 1'b1; base_address = 16'h0020; stride = 16'h0001; length = 12'd2;
      repeat_cnt = 4'd0; addr_ready = 1'b1;
      @(negedge core_clk);
      start = 1'b0;
      @(negedge core_clk);
      chk("fin_abort_last", 32'(last), 32'd1);
      abort = 1'b1;
      @(negedge core_clk);
      abort = 1'b0;
      chk_idle_outputs("fin_abort");
      @(negedge core_clk);
      chk("fin_abort_no_done", 32'(done), 32'd0);

      // Abort has no effect in IDLE, even alongside start
      start = 1'b1; abort = 1'b1; base_address = 16'h0005; stride = 16'h0001;
      length = 12'd1; repeat_cnt = 4'd0; addr_ready = 1'b1;
      @(negedge core_clk);
      start = 1'b0; abort = 1'b0;
      chk("idle_abort_valid", 32'(addr_valid), 32'd1);
      chk("idle_abort_addr", 32'(address), 32'h0014);
      chk("idle_abort_last", 32'(last), 32'd1);
      @(negedge core_clk);
      chk("idle_abort_done", 32'(done), 32'd1);
      @(negedge core_clk);

      // Reset in the middle of a run
      start = 1'b1; base_address = 16'h0300; stride = 16'h0001; length = 12'd6;
      repeat_cnt = 4'd0; addr_ready = 1'b1;
      @(negedge core_clk);
      start = 1'b0;
      @(negedge core_clk);
      chk("pre_reset_addr", 32'(address), 32'h0C04);
      reset = 1'b1;
      @(negedge core_clk);
      reset = 1'b0;
      chk_idle_outputs("mid_reset");
      chk("mid_reset_address", 32'(address), 32'd0);
      addr_ready = 1'b0;
      @(negedge core_clk);

      for (int i = 0; i < 25; i++) begin
         do_run(16'($urandom), 16'($urandom), 12'($urandom_range(0, 10)),
                4'($urandom_range(0, 3)), int'($urandom_range(0, 2)), fa, la, nb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/strided_addr_generator.md
# strided_addr_generator

Parametrised successor to the interface-unit address generator. It produces a strided word-address stream with a valid/ready handshake, an explicit beat count and an optional multi-pass replay. It sits between the interface-unit controller and the GLB/off-chip port. Addresses are emitted byte-aligned.

## Interface
- ADDR_WIDTH, 16, width of word and byte address
- LEN_WIDTH, 12, width of beat counter/length
- BYTE_SHIFT, 2, left shift applied to word address on output (log2 bytes per word)
- REP_WIDTH, 4, width of repeat count
- core_clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch request, sampled only in IDLE
- base_address  in  ADDR_WIDTH  first word address, latched on accepted start
- stride  in  ADDR_WIDTH  word increment per beat, latched on accepted start
- length  in  LEN_WIDTH  beats per pass, latched; 0 = no beats
- repeat_cnt  in  REP_WIDTH  extra passes (passes = repeat_cnt+1), latched
- abort  in  1  terminate run without done
- addr_ready  in  1  consumer accepts current address
- addr_valid  out  1  address is valid
- address  out  ADDR_WIDTH  (word_addr << BYTE_SHIFT), truncated to ADDR_WIDTH
- last  out  1  current beat is final beat of final pass (qualified by addr_valid)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final handshake

## Operation
- States: IDLE, RUN, DONE; encoding free.
- IDLE: start=1 latches base/stride/length/repeat_cnt, word_addr<=base, beat_cnt<=0, pass_cnt<=0. The block goes to RUN if length!=0, else DONE. Other inputs are ignored.
- RUN: addr_valid=1. A handshake occurs when addr_valid & addr_ready.
  - Handshake with beat_cnt != length-1: word_addr += stride (mod 2^ADDR_WIDTH, wraps silently), beat_cnt++.
  - Handshake with beat_cnt == length-1 and pass_cnt != latched repeat_cnt: word_addr<=base, beat_cnt<=0, pass_cnt++. The block stays in RUN with no bubble.
  - Handshake on final beat of final pass: the block goes to DONE.
  - No handshake: all registers hold. address is stable while addr_valid=1 and addr_ready=0.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- abort=1 in RUN: the block goes to IDLE next cycle. Any handshake in that cycle is still counted by the consumer, but no done is generated. abort is ignored in IDLE and DONE.
- abort and the final handshake in the same cycle: abort wins, so the block goes to IDLE with no done.
- start while busy: ignored and not queued.
- Input changes after latch have no effect until the next accepted start.

## Timing
- Reset values: addr_valid=0, address=0, last=0, busy=0, done=0. word_addr, beat_cnt and pass_cnt are 0; state is IDLE.
- start accepted at edge N: addr_valid=1 with address=base<<BYTE_SHIFT from cycle N+1.
- Output is 1 beat per cycle when addr_ready is held high. A run of length L with R repeats takes L*(R+1) cycles in RUN plus 1 cycle in DONE.
- done is high in the cycle after the final handshake. The earliest next start is accepted the cycle after done.
- length=0: done is high in the cycle after start, with no addr_valid.
- All outputs are decoded from registered state only; no combinational path exists from addr_ready, start or abort to any output.
- reset mid-run: outputs return to reset values at the next edge.

## Configuration
- STRIDED_ADDR_REPEAT_EN:
  - When defined, repeat_cnt and pass_cnt are implemented as specified.
  - When undefined, the repeat_cnt port is kept but ignored, and pass_cnt is removed. Each run is a single pass and last marks beat length-1.

## Test plan
- base=0x0010, stride=1, length=4, repeat=0, ready=1 -> addresses 0x0040, 0x0044, 0x0048, 0x004C on consecutive cycles. last is high on 0x004C, and done is high one cycle later.
- base=0x0100, stride=3, length=3, repeat=2 (macro on) -> 9 beats: word addresses 0x100, 0x103, 0x106 repeated ×3. last is high only on beat 9. With macro off: 3 beats only.
- addr_ready toggled 1,0,0,1 during run -> address and last hold while ready=0. No beat is skipped or duplicated, and the beat count equals length.
- base=0xFFFE, stride=1, length=3, BYTE_SHIFT=0 -> addresses 0xFFFE, 0xFFFF, 0x0000.
- length=0 with start -> addr_valid stays 0, done pulses one cycle later, busy is high for exactly 1 cycle.
- abort at beat 2 of length=8, and separately reset mid-run, and start asserted during RUN -> IDLE next cycle with no done. All outputs are at reset values after reset. The start asserted during RUN is ignored.
